// File: rtl/alu_defs.sv
// Shared definitions for the 8-bit ALU datapath: opcodes, flag bit
// positions and execute-stage FSM states.
package alu_defs;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        XOR = 3'd4,
        SHL = 3'd5,
        SHR = 3'd6,
        MUL = 3'd7
    } op_e;

    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one partial product per clock.
// Ports: clock, reset (async, active-low), load (capture a/b, clear acc),
//        a/b operands, product (accumulator after the current step),
//        last (the step taken at the next edge is the final one).
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 last
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               run_q, run_d;
    logic [2*WIDTH-1:0] step;

    // Accumulator value once the current multiplier bit is folded in.
    assign step    = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product = step;
    assign last    = run_q && (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = step;
            cnt_d    = cnt_q + 1'b1;
            if (last) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

endmodule

// File: rtl/alu_unit.sv
// Operand registers and execute stage: single-cycle logic/add/shift ops
// and an 8-step MUL, with registered result, flags {C,Z,N} and done pulse.
// Ports: clock, reset (async, active-low), bus_in, load_a, load_b, op,
//        start -> result[2W-1:0], flags[2:0], busy, done.
module alu_unit
    import alu_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     bus_in,
    input  logic                 load_a,
    input  logic                 load_b,
    input  logic [2:0]           op,
    input  logic                 start,
    output logic [2*WIDTH-1:0]   result,
    output logic [2:0]           flags,
    output logic                 busy,
    output logic                 done
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [2:0]         flags_q, flags_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               mul_load;
    logic               mul_last;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH:0]     r_short;
    op_e                op_s;

    assign op_s = op_e'(op);

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clock   (clock),
        .reset   (reset),
        .load    (mul_load),
        .a       (a_q),
        .b       (b_q),
        .product (mul_product),
        .last    (mul_last)
    );

    // Single-cycle ops: bit WIDTH carries C (borrow for SUB).
    always_comb begin
        r_short = '0;
        unique case (op_s)
            ADD: r_short = {1'b0, a_q} + {1'b0, b_q};
            SUB: r_short = {1'b0, a_q} - {1'b0, b_q};
            AND: r_short = {1'b0, a_q & b_q};
            OR:  r_short = {1'b0, a_q | b_q};
            XOR: r_short = {1'b0, a_q ^ b_q};
            SHL: r_short = {a_q, 1'b0};
            SHR: r_short = {a_q[0], 1'b0, a_q[WIDTH-1:1]};
            MUL: r_short = '0;
            default: r_short = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        a_d      = load_a ? bus_in : a_q;
        b_d      = load_b ? bus_in : b_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        mul_load = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op_s == MUL) begin
                        mul_load = 1'b1;
                        state_d  = S_MUL;
                    end else begin
                        result_d = {{(WIDTH-1){1'b0}}, r_short};
                        flags_d[FLAG_C] = r_short[WIDTH];
                        flags_d[FLAG_Z] = (r_short[WIDTH-1:0] == '0);
                        flags_d[FLAG_N] = r_short[WIDTH-1];
                        done_d   = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (mul_last) begin
                    result_d = mul_product;
                    flags_d[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
                    flags_d[FLAG_Z] = (mul_product == '0);
                    flags_d[FLAG_N] = mul_product[2*WIDTH-1];
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_MUL);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign flags  = flags_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
